// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and state encodings for the byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_BYTES_DEF = 16;
  localparam int unsigned LINE_LN        = 8 * LINE_BYTES_DEF;

  typedef logic [ADDR_W-1:0]  addr_tp;
  typedef logic [WORD_W-1:0]  word_tp;
  typedef logic [LINE_LN-1:0] line_tp;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    LOAD,
    STORE,
    DONE
  } mc_state_e;

  // Load/store request as presented by the load/store buffer.
  typedef struct packed {
    logic       wr;
    addr_tp     addr;
    logic [1:0] len;
    word_tp     wdata;
  } ls_req_t;

  // Byte count of a load/store; the illegal length code 2 is treated as a word.
  function automatic logic [2:0] ls_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serialises icache line refills and load/store accesses onto the
// 8-bit RAM/IO bus, with ls-over-fc priority, rollback and IO write back-pressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter logic [1:0]  IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    mc_rb,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    mc_fc_ena,
  input  logic [31:0]             mc_fc_addr,
  output logic                    mc_fc_done,
  output logic [8*LINE_BYTES-1:0] mc_fc_line,
  input  logic                    mc_ls_ena,
  input  logic                    mc_ls_wr,
  input  logic [31:0]             mc_ls_addr,
  input  logic [1:0]              mc_ls_len,
  input  logic [31:0]             mc_ls_wdata,
  output logic                    mc_ls_done,
  output logic [31:0]             mc_ls_rdata
);

  localparam int unsigned LN = 8 * LINE_BYTES;
  localparam int unsigned CW = $clog2(LINE_BYTES + 1);

  mc_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   nbytes_q, nbytes_d;
  addr_tp          base_q, base_d;
  word_tp          wdata_q, wdata_d;
  logic [LN-1:0]   buf_q, buf_d;
  logic            a_vld_q, a_vld_d;
  logic [CW-1:0]   a_idx_q, a_idx_d;
  logic            d_vld_q, d_vld_d;
  logic [CW-1:0]   d_idx_q, d_idx_d;
  logic            frz_q;
  logic [7:0]      din_hold_q;
  addr_tp          mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            wr_q, wr_d;
  logic            fc_done_q, fc_done_d;
  logic [LN-1:0]   fc_line_q, fc_line_d;
  logic            ls_done_q, ls_done_d;
  word_tp          ls_rdata_q, ls_rdata_d;

  ls_req_t         ls_req;
  logic            io_blk;
  logic [7:0]      din_c;
  logic [LN-1:0]   buf_fill;
  word_tp          wsh;

  assign ls_req = '{wr: mc_ls_wr, addr: mc_ls_addr, len: mc_ls_len, wdata: mc_ls_wdata};

  // A pending IO-region write is turned into an idle cycle while the UART buffer is full.
  assign io_blk = (state_q == STORE) && wr_q && (mem_a_q[17:16] == IO_ADDR_HI) && io_buffer_full;

  // The byte returned in the first stalled cycle is parked and consumed on resume.
  assign din_c = frz_q ? din_hold_q : mem_din;

  always_comb begin
    buf_fill = buf_q;
    for (int unsigned i = 0; i < LINE_BYTES; i++) begin
      if (d_idx_q == CW'(i)) buf_fill[8*i +: 8] = din_c;
    end
    wsh = wdata_q >> {cnt_q, 3'b000};
  end

  // Next-state and next-output logic for the shared byte sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    a_vld_d    = FALSE;
    a_idx_d    = a_idx_q;
    d_vld_d    = a_vld_q;
    d_idx_d    = a_idx_q;
    mem_a_d    = '0;
    mem_dout_d = '0;
    wr_d       = FALSE;
    fc_done_d  = FALSE;
    fc_line_d  = fc_line_q;
    ls_done_d  = FALSE;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (!mc_rb && mc_ls_ena) begin
          base_d   = ls_req.addr;
          wdata_d  = ls_req.wdata;
          nbytes_d = CW'(ls_bytes(ls_req.len));
          buf_d    = '0;
          cnt_d    = CW'(1);
          mem_a_d  = ls_req.addr;
          if (ls_req.wr) begin
            state_d    = STORE;
            mem_dout_d = ls_req.wdata[7:0];
            wr_d       = TRUE;
          end else begin
            state_d = LOAD;
            a_vld_d = TRUE;
            a_idx_d = '0;
          end
        end else if (!mc_rb && mc_fc_ena) begin
          state_d  = IFETCH;
          base_d   = mc_fc_addr;
          nbytes_d = CW'(LINE_BYTES);
          buf_d    = '0;
          cnt_d    = CW'(1);
          mem_a_d  = mc_fc_addr;
          a_vld_d  = TRUE;
          a_idx_d  = '0;
        end
      end

      IFETCH, LOAD: begin
        if (mc_rb) begin
          state_d = IDLE;
          d_vld_d = FALSE;
        end else begin
          if (cnt_q < nbytes_q) begin
            mem_a_d = base_q + ADDR_W'(cnt_q);
            a_vld_d = TRUE;
            a_idx_d = cnt_q;
            cnt_d   = cnt_q + 1'b1;
          end
          if (d_vld_q) begin
            buf_d = buf_fill;
            if (d_idx_q == nbytes_q - 1'b1) begin
              state_d = DONE;
              if (state_q == IFETCH) begin
                fc_done_d = TRUE;
                fc_line_d = buf_fill;
              end else begin
                ls_done_d  = TRUE;
                ls_rdata_d = buf_fill[31:0];
              end
            end
          end
        end
      end

      STORE: begin
        if (io_blk) begin
          mem_a_d    = mem_a_q;
          mem_dout_d = mem_dout_q;
          wr_d       = wr_q;
        end else if (cnt_q == nbytes_q) begin
          state_d   = DONE;
          ls_done_d = TRUE;
        end else begin
          mem_a_d    = base_q + ADDR_W'(cnt_q);
          mem_dout_d = wsh[7:0];
          wr_d       = TRUE;
          cnt_d      = cnt_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State register; rdy=0 freezes everything except the parked read byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      a_vld_q    <= FALSE;
      a_idx_q    <= '0;
      d_vld_q    <= FALSE;
      d_idx_q    <= '0;
      frz_q      <= FALSE;
      din_hold_q <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= FALSE;
      fc_done_q  <= FALSE;
      fc_line_q  <= '0;
      ls_done_q  <= FALSE;
      ls_rdata_q <= '0;
    end else if (!rdy) begin
      frz_q <= TRUE;
      if (!frz_q) din_hold_q <= mem_din;
    end else begin
      frz_q      <= FALSE;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      a_vld_q    <= a_vld_d;
      a_idx_q    <= a_idx_d;
      d_vld_q    <= d_vld_d;
      d_idx_q    <= d_idx_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
      fc_done_q  <= fc_done_d;
      fc_line_q  <= fc_line_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = wr_q & rdy & ~io_blk;
  assign mc_fc_done  = fc_done_q;
  assign mc_fc_line  = fc_line_q;
  assign mc_ls_done  = ls_done_q;
  assign mc_ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte-wide RAM.
module tb_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst, rdy, mc_rb, io_buffer_full;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         mc_fc_ena;
  logic [31:0]  mc_fc_addr;
  logic         mc_fc_done;
  logic [127:0] mc_fc_line;
  logic         mc_ls_ena, mc_ls_wr;
  logic [31:0]  mc_ls_addr;
  logic [1:0]   mc_ls_len;
  logic [31:0]  mc_ls_wdata;
  logic         mc_ls_done;
  logic [31:0]  mc_ls_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int w0;
  logic [127:0] line_a, line_b;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mc_rb(mc_rb), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .mc_fc_ena(mc_fc_ena), .mc_fc_addr(mc_fc_addr), .mc_fc_done(mc_fc_done),
    .mc_fc_line(mc_fc_line), .mc_ls_ena(mc_ls_ena), .mc_ls_wr(mc_ls_wr),
    .mc_ls_addr(mc_ls_addr), .mc_ls_len(mc_ls_len), .mc_ls_wdata(mc_ls_wdata),
    .mc_ls_done(mc_ls_done), .mc_ls_rdata(mc_ls_rdata)
  );

  // RAM contents used by the vectors.
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (a >= 32'h1230 && a <= 32'h123F) return 8'h10 + {4'h0, a[3:0]};
    if (a <= 32'h000F)                  return 8'hA0 + {4'h0, a[3:0]};
    case (a)
      32'h2004: return 8'h78;
      32'h2005: return 8'h56;
      32'h2006: return 8'h34;
      32'h2007: return 8'h12;
      default:  return 8'hEE;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_req(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] wdata);
    mc_ls_ena   = 1'b1;
    mc_ls_wr    = wr;
    mc_ls_addr  = addr;
    mc_ls_len   = len;
    mc_ls_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      line_a[8*i +: 8] = 8'(8'h10 + i);
      line_b[8*i +: 8] = 8'(8'hA0 + i);
    end
    rst = 1'b0; rdy = 1'b1; mc_rb = 1'b0; io_buffer_full = 1'b0;
    mc_fc_ena = 1'b0; mc_fc_addr = '0;
    mc_ls_ena = 1'b0; mc_ls_wr = 1'b0; mc_ls_addr = '0; mc_ls_len = '0; mc_ls_wdata = '0;
    #12;
    check("rst_a",     128'(mem_a), 128'(0));
    check("rst_wr",    128'(mem_wr), 128'(0));
    check("rst_dout",  128'(mem_dout), 128'(0));
    check("rst_fdone", 128'(mc_fc_done), 128'(0));
    check("rst_ldone", 128'(mc_ls_done), 128'(0));
    rst = 1'b1;
    tick(); tick();

    // Line refill at 0x1230.
    mc_fc_ena = 1'b1; mc_fc_addr = 32'h1230;
    tick();
    mc_fc_ena = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      #1;
      check("rf_a", 128'(mem_a), (c <= 16) ? 128'(32'h1230 + 32'(c - 1)) : 128'(0));
      check("rf_done", 128'(mc_fc_done), 128'(c == 18));
      if (c == 18) check("rf_line", mc_fc_line, line_a);
      tick();
    end

    // Simultaneous fc and 4B load: load wins, fc follows.
    mc_fc_ena = 1'b1; mc_fc_addr = 32'h0;
    ls_req(1'b0, 32'h2004, 2'd3, 32'h0);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c == 8) mc_fc_ena = 1'b0;
      #1;
      check("sim_ldone", 128'(mc_ls_done), 128'(c == 6));
      if (c == 6) check("sim_rdata", 128'(mc_ls_rdata), 128'(32'h12345678));
      if (c == 9) check("sim_fa", 128'(mem_a), 128'(32'h1));
      check("sim_fdone", 128'(mc_fc_done), 128'(c == 25));
      if (c == 25) check("sim_line", mc_fc_line, line_b);
      tick();
    end

    // 2-byte store.
    w0 = wr_cnt;
    ls_req(1'b1, 32'h100, 2'd1, 32'hAABBCCDD);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("st_wr", 128'(mem_wr), 128'(c <= 2));
      if (c <= 2) begin
        check("st_a", 128'(mem_a), 128'(32'h100 + 32'(c - 1)));
        check("st_dout", 128'(mem_dout), (c == 1) ? 128'(8'hDD) : 128'(8'hCC));
      end
      check("st_done", 128'(mc_ls_done), 128'(c == 3));
      tick();
    end
    check("st_nwr", 128'(wr_cnt - w0), 128'(2));

    // IO write held off while the UART buffer is full.
    w0 = wr_cnt;
    io_buffer_full = 1'b1;
    ls_req(1'b1, 32'h30000, 2'd0, 32'h0000005A);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 6) io_buffer_full = 1'b0;
      #1;
      check("io_wr", 128'(mem_wr), 128'(c == 6));
      if (c == 6) begin
        check("io_a", 128'(mem_a), 128'(32'h30000));
        check("io_dout", 128'(mem_dout), 128'(8'h5A));
      end
      check("io_done", 128'(mc_ls_done), 128'(c == 7));
      tick();
    end
    check("io_nwr", 128'(wr_cnt - w0), 128'(1));

    // Rollback in cycle 7 of a refill, then a 1B load proves the controller is idle.
    mc_fc_ena = 1'b1; mc_fc_addr = 32'h1230;
    tick();
    mc_fc_ena = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      mc_rb = (c == 7);
      if (c == 8) ls_req(1'b0, 32'h2004, 2'd0, 32'h0);
      if (c == 9) mc_ls_ena = 1'b0;
      #1;
      check("rb_fdone", 128'(mc_fc_done), 128'(0));
      if (c == 8) check("rb_a", 128'(mem_a), 128'(0));
      if (c == 9) check("rb_la", 128'(mem_a), 128'(32'h2004));
      check("rb_ldone", 128'(mc_ls_done), 128'(c == 11));
      if (c == 11) check("rb_rdata", 128'(mc_ls_rdata), 128'(32'h00000078));
      tick();
    end
    check("rb_line", mc_fc_line, line_b);

    // Rollback during a 4B store is ignored.
    w0 = wr_cnt;
    ls_req(1'b1, 32'h140, 2'd3, 32'h01020304);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      mc_rb = (c <= 5);
      #1;
      check("sr_wr", 128'(mem_wr), 128'(c <= 4));
      if (c <= 4) begin
        check("sr_a", 128'(mem_a), 128'(32'h140 + 32'(c - 1)));
        check("sr_dout", 128'(mem_dout), 128'(8'(5 - c)));
      end
      check("sr_done", 128'(mc_ls_done), 128'(c == 5));
      tick();
    end
    mc_rb = 1'b0;
    check("sr_nwr", 128'(wr_cnt - w0), 128'(4));

    // rdy=0 during a store write cycle delays the write by one cycle.
    w0 = wr_cnt;
    ls_req(1'b1, 32'h180, 2'd0, 32'h00000077);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      rdy = (c != 1);
      #1;
      check("rs_wr", 128'(mem_wr), 128'(c == 2));
      if (c == 2) check("rs_a", 128'(mem_a), 128'(32'h180));
      check("rs_done", 128'(mc_ls_done), 128'(c == 3));
      tick();
    end
    check("rs_nwr", 128'(wr_cnt - w0), 128'(1));

    // rdy=0 for three cycles mid-load delays completion by three cycles.
    ls_req(1'b0, 32'h2004, 2'd3, 32'h0);
    tick();
    mc_ls_ena = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      rdy = !(c >= 3 && c <= 5);
      #1;
      check("rl_done", 128'(mc_ls_done), 128'(c == 9));
      if (c == 9) check("rl_rdata", 128'(mc_ls_rdata), 128'(32'h12345678));
      tick();
    end
    rdy = 1'b1;

    // Asynchronous reset mid-refill clears outputs without a clock edge.
    mc_fc_ena = 1'b1; mc_fc_addr = 32'h1230;
    tick();
    mc_fc_ena = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("ar_a",     128'(mem_a), 128'(0));
    check("ar_wr",    128'(mem_wr), 128'(0));
    check("ar_line",  mc_fc_line, 128'(0));
    check("ar_rdata", 128'(mc_ls_rdata), 128'(0));
    check("ar_fdone", 128'(mc_fc_done), 128'(0));
    rst = 1'b1;
    tick(); tick();
    #1;
    check("ar_idle_a", 128'(mem_a), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the 8-bit single-port RAM/IO bus and the CPU's memory clients.
- Serves 16-byte line refills for the instruction cache (fc channel) and 1/2/4-byte loads and stores for the load/store buffer (ls channel).
- Serialises every transfer into byte accesses, arbitrates the two channels and supports rollback of speculative traffic.

Parameters:
- LINE_BYTES, 16, bytes per icache line; mc_fc_line width = 8*LINE_BYTES.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-low (0 = reset)
- rdy  in  1  global ready; 0 freezes the block
- mc_rb  in  1  rollback: abort speculative fetch/load
- io_buffer_full  in  1  UART buffer full; blocks IO-region writes
- mem_din  in  8  RAM read byte, valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- mc_fc_ena  in  1  icache refill request (level)
- mc_fc_addr  in  32  line base address; bits [3:0] are 0
- mc_fc_done  out  1  one-cycle pulse: line valid
- mc_fc_line  out  128  refilled line; byte i at [8i+7:8i]
- mc_ls_ena  in  1  load/store request (level)
- mc_ls_wr  in  1  1 = store, 0 = load
- mc_ls_addr  in  32  byte address
- mc_ls_len  in  2  0 = 1B, 1 = 2B, 3 = 4B; 2 is illegal and treated as 4B
- mc_ls_wdata  in  32  store data, little-endian
- mc_ls_done  out  1  one-cycle pulse: access complete
- mc_ls_rdata  out  32  load data, zero-extended, little-endian

Behaviour:
- Reset (rst=0, asynchronous) forces state IDLE and counters 0. It also drives 0 on mem_a, mem_dout, mem_wr, mc_fc_done, mc_fc_line, mc_ls_done and mc_ls_rdata. The same applies when rst is asserted mid-transfer; the partial line or word is discarded.
- rdy=0: all registers hold. mem_wr is forced to 0 for that cycle so no write is repeated or lost. The paused byte is reissued when rdy returns to 1.
- States: IDLE, IFETCH, LOAD, STORE, DONE.
- IDLE:
  - mem_wr=0.
  - At a clock edge with mc_ls_ena=1, latch addr, len and data, then go to LOAD or STORE.
  - Otherwise, with mc_fc_ena=1, latch mc_fc_addr and go to IFETCH.
  - ls always has priority; a pending fc simply waits.
- Byte counter cnt addresses bytes base+0 .. base+N-1. N is LINE_BYTES for IFETCH and len+1 for LOAD/STORE.
- Read timing (IFETCH/LOAD), with the acceptance edge as cycle 0:
  - mem_a = base+k in cycle k+1.
  - mem_din is captured into byte k at the end of cycle k+2.
  - Done is pulsed in cycle N+2, so a full line completes in cycle 18.
  - mem_a is 0 during DONE.
- Write timing (STORE):
  - Cycle k+1 drives mem_a = base+k, mem_dout = wdata byte k and mem_wr=1.
  - mc_ls_done is pulsed in cycle N+1.
  - If addr[17:16]==IO_ADDR_HI and io_buffer_full=1, the write cycle is replaced by an idle cycle (mem_wr=0) and cnt holds until io_buffer_full=0.
- DONE:
  - Exactly one cycle with the matching done=1.
  - mc_fc_line or mc_ls_rdata is stable from this cycle until the next transfer of the same channel completes.
  - Requests are ignored in DONE, which gives requesters one edge to drop ena.
  - The next state is IDLE.
- Rollback:
  - mc_rb=1 in IFETCH or LOAD: next state IDLE, no done pulse, output data registers unchanged.
  - mc_rb in STORE is ignored; stores are committed and always complete.
  - mc_rb in IDLE or DONE discards requests sampled that edge and leaves the DONE pulse intact.
- Address arithmetic is 32-bit modulo 2^32; base+k wraps with no fault.
- mc_ls_rdata bytes above len+1 are 0.

Decomposition:
- Shared utils header holds ADDR_TP, WORD_TP, LINE_TP/LINE_LN, TRUE/FALSE, the IO region constant and the mem_ctrl state encodings.
- No sub-module is natural. The byte sequencer is shared by all three transfer types and stays inline in one always block plus output assigns.

Test Plan:
- Refill: mc_fc_ena=1 with addr 0x1230, RAM byte i = 0x10+i -> mem_a runs 0x1230..0x123F in cycles 1..16; mc_fc_done=1 in cycle 18 only; mc_fc_line = 0x1F1E..1110.
- Simultaneous requests: fc (0x0) and ls load 4B at 0x2004 (bytes 78 56 34 12) in the same cycle -> load first, mc_ls_rdata=0x12345678 with done in cycle 6; fc accepted after DONE.
- Store 2B: wdata 0xAABBCCDD to 0x100 -> mem_wr=1 at 0x100 with dout 0xDD, then 0x101 with dout 0xCC; mc_ls_done in cycle 3; no write to 0x102.
- IO stall: store 1B to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 for 5 cycles, then a single write; done exactly one cycle later.
- Rollback: mc_rb=1 in cycle 7 of a refill -> no mc_fc_done, IDLE next cycle; mc_rb during a store -> store completes and done pulses.
- Reset/rdy: rdy=0 for 3 cycles mid-load -> same result delayed 3 cycles; rst=0 mid-refill -> all outputs 0 immediately without a clock edge.
